// File: rtl/seg7_pkg.sv
// ----------------------------------------------------------------------------
// seg7_pkg
// Shared constants for the 7-segment display path: the 16 hex-digit patterns
// in active-low gfedcba order (bit 0 = segment a), the blank pattern, the
// decoder result record and the reader FSM state encoding. The DE1 display
// encoder and the read-back checkers both import this package so that the
// two directions can never disagree on a glyph.
// No ports (package).
// ----------------------------------------------------------------------------
package seg7_pkg;

   // Active-low glyphs: a 0 bit lights the segment.
   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_A     = 7'h08;
   localparam logic [6:0] SEG_B     = 7'h03;
   localparam logic [6:0] SEG_C     = 7'h46;
   localparam logic [6:0] SEG_D     = 7'h21;
   localparam logic [6:0] SEG_E     = 7'h06;
   localparam logic [6:0] SEG_F     = 7'h0E;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   localparam logic [6:0] SEG_TABLE [16] = '{
      SEG_0, SEG_1, SEG_2, SEG_3, SEG_4, SEG_5, SEG_6, SEG_7,
      SEG_8, SEG_9, SEG_A, SEG_B, SEG_C, SEG_D, SEG_E, SEG_F
   };

   // Reader FSM encoding, kept as plain constants so older netlists and
   // probes that match on the raw state value keep working.
   localparam int unsigned ST_W = 2;
   localparam logic [ST_W-1:0] S_HI  = 2'd0;   // waiting for high nibble
   localparam logic [ST_W-1:0] S_LO  = 2'd1;   // waiting for low nibble
   localparam logic [ST_W-1:0] S_OUT = 2'd2;   // holding an assembled byte

   // Result of classifying one pattern.
   typedef struct packed {
      logic       is_hex;
      logic       is_blank;
      logic [3:0] nibble;
   } seg_decode_t;

   // Forward mapping used by the display encoder; polarity selects the
   // board convention (1 = active-low segments).
   function automatic logic [6:0] seg_encode(input logic [3:0] nib,
                                             input bit active_low);
      logic [6:0] pat;
      pat = SEG_TABLE[nib];
      return active_low ? pat : ~pat;
   endfunction

endpackage

// File: rtl/seg7_lookup.sv
// ----------------------------------------------------------------------------
// seg7_lookup
// Purely combinational inverse of the hex-digit glyph table. The incoming
// pattern is first normalised to the active-low convention, then classified
// as a hex digit (with its value), the blank glyph, or neither.
// Ports:
//   seg_in   in  7  segment pattern, gfedcba
//   is_hex   out 1  pattern is one of the 16 hex glyphs
//   is_blank out 1  pattern is the all-off glyph
//   nibble   out 4  digit value when is_hex, else 0
// ----------------------------------------------------------------------------
module seg7_lookup
   import seg7_pkg::*;
#(
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic [6:0] seg_in,
   output logic       is_hex,
   output logic       is_blank,
   output logic [3:0] nibble
);

   logic [6:0] seg_n;

   // All table constants are active-low; flip active-high input once here.
   assign seg_n = ACTIVE_LOW ? seg_in : ~seg_in;

   always_comb begin
      is_hex   = 1'b1;
      nibble   = '0;
      is_blank = (seg_n == SEG_BLANK);
      case (seg_n)
         SEG_0:   nibble = 4'h0;
         SEG_1:   nibble = 4'h1;
         SEG_2:   nibble = 4'h2;
         SEG_3:   nibble = 4'h3;
         SEG_4:   nibble = 4'h4;
         SEG_5:   nibble = 4'h5;
         SEG_6:   nibble = 4'h6;
         SEG_7:   nibble = 4'h7;
         SEG_8:   nibble = 4'h8;
         SEG_9:   nibble = 4'h9;
         SEG_A:   nibble = 4'hA;
         SEG_B:   nibble = 4'hB;
         SEG_C:   nibble = 4'hC;
         SEG_D:   nibble = 4'hD;
         SEG_E:   nibble = 4'hE;
         SEG_F:   nibble = 4'hF;
         default: is_hex = 1'b0;
      endcase
   end

endmodule

// File: rtl/seg7_reader.sv
// ----------------------------------------------------------------------------
// seg7_reader
// Reads back a handshaked stream of 7-segment patterns, turns each into a
// nibble and pairs nibbles into bytes (high nibble first). Used on the
// display bus to check that what HEX5/HEX4 show matches the value on LEDR.
// Unrecognised patterns are flagged and counted (saturating).
// Ports:
//   clk        in  1      rising-edge clock
//   resetn     in  1      synchronous active-low reset
//   seg_in     in  7      segment pattern, gfedcba
//   seg_valid  in  1      seg_in is valid
//   seg_ready  out 1      pattern can be accepted (decoded from state only)
//   byte_out   out 8      {high nibble, low nibble}
//   byte_valid out 1      byte_out is valid
//   byte_ready in  1      consumer takes byte_out
//   err_pulse  out 1      one cycle after an unrecognised pattern is accepted
//   err_count  out ERR_W  saturating count of unrecognised patterns
//   err_clr    in  1      synchronous clear of err_count (beats increment)
// ----------------------------------------------------------------------------
module seg7_reader
   import seg7_pkg::*;
#(
   parameter bit          ACTIVE_LOW = 1'b1,
   parameter int unsigned ERR_W      = 8
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic [6:0]       seg_in,
   input  logic             seg_valid,
   output logic             seg_ready,
   output logic [7:0]       byte_out,
   output logic             byte_valid,
   input  logic             byte_ready,
   output logic             err_pulse,
   output logic [ERR_W-1:0] err_count,
   input  logic             err_clr
);

   seg_decode_t dec;

   logic [ST_W-1:0]  state_q, state_d;
   logic [3:0]       hi_q, hi_d;
   logic [7:0]       byte_q, byte_d;
   logic             bvalid_q, bvalid_d;
   logic             pulse_q, pulse_d;
   logic [ERR_W-1:0] cnt_q, cnt_d;

   logic             accept;
   logic             err_evt;

   seg7_lookup #(
      .ACTIVE_LOW (ACTIVE_LOW)
   ) u_lookup (
      .seg_in   (seg_in),
      .is_hex   (dec.is_hex),
      .is_blank (dec.is_blank),
      .nibble   (dec.nibble)
   );

   assign seg_ready = (state_q != S_OUT);
   assign accept    = seg_valid && seg_ready;

   // FSM and datapath next-state.
   always_comb begin
      state_d = state_q;
      hi_d    = hi_q;
      byte_d  = byte_q;
      err_evt = 1'b0;
      case (state_q)
         S_HI: begin
            if (accept) begin
               if (dec.is_hex) begin
                  hi_d    = dec.nibble;
                  state_d = S_LO;
               end else if (!dec.is_blank) begin
                  err_evt = 1'b1;
               end
            end
         end
         S_LO: begin
            if (accept) begin
               if (dec.is_hex) begin
                  byte_d  = {hi_q, dec.nibble};
                  state_d = S_OUT;
               end else begin
                  // Blank resyncs silently; anything else is an error. In
                  // both cases the stored high nibble is abandoned.
                  state_d = S_HI;
                  err_evt = !dec.is_blank;
               end
            end
         end
         S_OUT: begin
            if (byte_ready) begin
               state_d = S_HI;
            end
         end
         default: state_d = S_HI;
      endcase
   end

   // byte_valid is registered from the next state so it rises on the same
   // edge that loads byte_out and falls on the handshake edge.
   always_comb begin
      bvalid_d = (state_d == S_OUT);
      pulse_d  = err_evt;
      cnt_d    = cnt_q;
      if (err_clr) begin
         cnt_d = '0;
      end else if (err_evt && (cnt_q != '1)) begin
         cnt_d = cnt_q + ERR_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q  <= S_HI;
         hi_q     <= '0;
         byte_q   <= '0;
         bvalid_q <= 1'b0;
         pulse_q  <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         hi_q     <= hi_d;
         byte_q   <= byte_d;
         bvalid_q <= bvalid_d;
         pulse_q  <= pulse_d;
         cnt_q    <= cnt_d;
      end
   end

   assign byte_out   = byte_q;
   assign byte_valid = bvalid_q;
   assign err_pulse  = pulse_q;
   assign err_count  = cnt_q;

endmodule

// File: tb/tb_seg7_reader.sv
// ----------------------------------------------------------------------------
// tb_seg7_reader
// Two readers (active-low and active-high) driven by the same pattern
// stream, the second one seeing inverted codes. Expected bytes and error
// counts come from a transaction-level model of the pairing rules.
// ----------------------------------------------------------------------------
module tb_seg7_reader;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       resetn, seg_valid, byte_ready, err_clr;
   logic [6:0] seg_in, seg_in_n;
   assign seg_in_n = ~seg_in;

   logic       ready_a, bval_a, pulse_a;
   logic [7:0] bout_a, cnt_a;
   logic       ready_b, bval_b, pulse_b;
   logic [7:0] bout_b, cnt_b;

   seg7_reader #(.ACTIVE_LOW(1'b1), .ERR_W(8)) dut_a (
      .clk(clk), .resetn(resetn), .seg_in(seg_in), .seg_valid(seg_valid),
      .seg_ready(ready_a), .byte_out(bout_a), .byte_valid(bval_a),
      .byte_ready(byte_ready), .err_pulse(pulse_a), .err_count(cnt_a),
      .err_clr(err_clr)
   );

   seg7_reader #(.ACTIVE_LOW(1'b0), .ERR_W(8)) dut_b (
      .clk(clk), .resetn(resetn), .seg_in(seg_in_n), .seg_valid(seg_valid),
      .seg_ready(ready_b), .byte_out(bout_b), .byte_valid(bval_b),
      .byte_ready(byte_ready), .err_pulse(pulse_b), .err_count(cnt_b),
      .err_clr(err_clr)
   );

   localparam logic [6:0] PAT_TAB [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   int total = 0;
   int bad   = 0;

   logic [7:0] exp_q [$];
   logic [7:0] got_a [$];
   logic [7:0] got_b [$];
   int pulses_a   = 0;
   int pulses_b   = 0;
   int exp_pulses = 0;
   int exp_cnt    = 0;
   bit have_hi    = 1'b0;
   logic [3:0] hi_nib = 4'h0;
   bit rand_br    = 1'b0;

   // 0..15 digit, 16 blank, -1 unrecognised
   function automatic int decode(input logic [6:0] p);
      if (p == 7'h7F) return 16;
      for (int i = 0; i < 16; i++) if (PAT_TAB[i] == p) return i;
      return -1;
   endfunction

   task automatic model_push(input logic [6:0] p);
      int d;
      d = decode(p);
      if (d < 0) begin
         exp_pulses++;
         if (exp_cnt < 255) exp_cnt++;
         have_hi = 1'b0;
      end else if (d == 16) begin
         have_hi = 1'b0;
      end else if (have_hi) begin
         exp_q.push_back({hi_nib, 4'(d)});
         have_hi = 1'b0;
      end else begin
         hi_nib  = 4'(d);
         have_hi = 1'b1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [6:0] p);
      int n;
      n = 0;
      seg_in    = p;
      seg_valid = 1'b1;
      while (ready_a !== 1'b1 && n < 50) begin
         if (rand_br) byte_ready = 1'($urandom_range(0, 1));
         tick();
         n++;
      end
      chk("accept_wait", 32'(n < 50), 32'd1);
      if (rand_br) byte_ready = 1'($urandom_range(0, 1));
      tick();
      seg_valid = 1'b0;
      model_push(p);
   endtask

   // Record handshakes and error pulses between edges.
   always @(negedge clk) begin
      if (resetn === 1'b1) begin
         if (bval_a === 1'b1 && byte_ready === 1'b1) got_a.push_back(bout_a);
         if (bval_b === 1'b1 && byte_ready === 1'b1) got_b.push_back(bout_b);
      end
      if (pulse_a === 1'b1) pulses_a++;
      if (pulse_b === 1'b1) pulses_b++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [6:0] p;
      int r, base;

      resetn = 1'b0; seg_valid = 1'b0; byte_ready = 1'b0; err_clr = 1'b0;
      seg_in = 7'h7F;
      tick(); tick();
      chk("rst_ready_a", ready_a, 1); chk("rst_ready_b", ready_b, 1);
      chk("rst_bval_a", bval_a, 0);   chk("rst_bval_b", bval_b, 0);
      chk("rst_bout_a", bout_a, 0);   chk("rst_bout_b", bout_b, 0);
      chk("rst_pulse_a", pulse_a, 0); chk("rst_pulse_b", pulse_b, 0);
      chk("rst_cnt_a", cnt_a, 0);     chk("rst_cnt_b", cnt_b, 0);
      resetn = 1'b1;
      tick();

      // 5 then d with consumer ready: one-cycle byte_valid.
      byte_ready = 1'b1;
      send(7'h12); send(7'h21);
      chk("t1_bout_a", bout_a, 8'h5D); chk("t1_bout_b", bout_b, 8'h5D);
      chk("t1_bval", bval_a, 1);
      tick();
      chk("t1_bval_drop", bval_a, 0);
      chk("t1_cnt", cnt_a, 0);
      chk("t1_count", got_a.size(), 1);

      // 0 then 1 with consumer stalled.
      byte_ready = 1'b0;
      send(7'h40); send(7'h79);
      for (int i = 0; i < 5; i++) begin
         chk("t2_bout_a", bout_a, 8'h01);
         chk("t2_bout_b", bout_b, 8'h01);
         chk("t2_bval", bval_a, 1);
         chk("t2_ready", ready_a, 0);
         tick();
      end
      byte_ready = 1'b1;
      tick();
      chk("t2_bval_drop", bval_a, 0);
      chk("t2_ready_back", ready_a, 1);

      // Blank resync discards E.
      send(7'h06); send(7'h7F); send(7'h0E); send(7'h46);
      chk("t3_bout_a", bout_a, 8'hFC); chk("t3_bout_b", bout_b, 8'hFC);
      chk("t3_cnt", cnt_a, 0);
      tick();

      // Errors in both nibble positions, no byte.
      base = got_a.size();
      send(7'h55);
      chk("t4_pulse", pulse_a, 1);
      send(7'h08); send(7'h55);
      chk("t4_cnt_a", cnt_a, 2); chk("t4_cnt_b", cnt_b, 2);
      tick();
      chk("t4_pulse_end", pulse_a, 0);
      chk("t4_pulses", pulses_a, 2);
      chk("t4_nobyte", got_a.size(), base);

      // Saturation, then clear beating a simultaneous error.
      for (int i = 0; i < 300; i++) begin
         do p = 7'($urandom); while (decode(p) != -1);
         send(p);
      end
      chk("t5_sat_a", cnt_a, 8'hFF); chk("t5_sat_b", cnt_b, 8'hFF);
      err_clr = 1'b1;
      send(7'h55);
      err_clr = 1'b0;
      exp_cnt = 0;
      chk("t5_clr_a", cnt_a, 0); chk("t5_clr_b", cnt_b, 0);
      chk("t5_clr_pulse", pulse_a, 1);
      tick();
      chk("t5_pulses_a", pulses_a, exp_pulses);
      chk("t5_pulses_b", pulses_b, exp_pulses);

      // Reset mid-byte drops the stale high nibble.
      send(7'h00);
      resetn = 1'b0;
      tick();
      resetn  = 1'b1;
      have_hi = 1'b0;
      exp_cnt = 0;
      chk("t6_rst_ready", ready_a, 1);
      send(7'h79); send(7'h24);
      chk("t6_bout_a", bout_a, 8'h12); chk("t6_bout_b", bout_b, 8'h12);
      chk("t6_bval", bval_a, 1);
      tick();

      // Random mix with random backpressure and idle gaps.
      rand_br = 1'b1;
      for (int i = 0; i < 400; i++) begin
         r = $urandom_range(0, 99);
         if (r < 70) p = PAT_TAB[$urandom_range(0, 15)];
         else if (r < 85) p = 7'h7F;
         else begin
            do p = 7'($urandom); while (decode(p) != -1);
         end
         send(p);
         if ($urandom_range(0, 3) == 0) begin
            byte_ready = 1'($urandom_range(0, 1));
            tick();
         end
      end
      rand_br    = 1'b0;
      byte_ready = 1'b1;
      repeat (4) tick();

      chk("final_count_a", got_a.size(), exp_q.size());
      chk("final_count_b", got_b.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i < got_a.size()) chk("final_byte_a", got_a[i], exp_q[i]);
         if (i < got_b.size()) chk("final_byte_b", got_b[i], exp_q[i]);
      end
      chk("final_cnt_a", cnt_a, exp_cnt);
      chk("final_cnt_b", cnt_b, exp_cnt);
      chk("final_pulses_a", pulses_a, exp_pulses);
      chk("final_pulses_b", pulses_b, exp_pulses);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/seg7_reader.md
# seg7_reader

Sequential 7-segment decoder: the inverse of the hex-digit display path. It accepts a handshaked stream of 7-segment patterns, maps each back to a 4-bit nibble, pairs nibbles into bytes (high nibble first), and presents each byte on a valid/ready output. Pattern errors are counted. It sits on the display bus as an in-system checker, so ALU results shown on HEX5/HEX4 can be read back and compared against LEDR.

## Interface
- `ACTIVE_LOW`, default 1: 1 means segment bit 0 = lit (DE1 HEX convention). 0 means 1 = lit, and the input is inverted before lookup.
- `ERR_W`, default 8: width of the error counter.

Ports:
- `clk` input 1: single clock. All state changes on the rising edge.
- `resetn` input 1: synchronous, active-low reset, sampled on the `clk` rising edge.
- `seg_in` input 7: segment pattern, bit order gfedcba (bit 0 = segment a).
- `seg_valid` input 1: `seg_in` is valid.
- `seg_ready` output 1: block can accept a pattern.
- `byte_out` output 8: assembled byte, {high nibble, low nibble}.
- `byte_valid` output 1: `byte_out` is valid.
- `byte_ready` input 1: consumer accepts `byte_out`.
- `err_pulse` output 1: one-cycle pulse when an unrecognised pattern is accepted.
- `err_count` output ERR_W: count of unrecognised patterns, saturating.
- `err_clr` input 1: synchronous clear of `err_count`.

## Operation
- Pattern table (active-low, hex): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.
- BLANK = 7F. Every other code is INVALID.
- An accept happens on a rising edge where `seg_valid && seg_ready`.
- FSM states: S_HI (waiting for high nibble), S_LO (waiting for low nibble), S_OUT (holding a byte).
- Reset state is S_HI.
- `seg_ready` = 1 in S_HI and S_LO; 0 in S_OUT.
- S_HI accepts:
  - hex digit: store it as the high nibble, go to S_LO;
  - BLANK: drop it, stay in S_HI;
  - INVALID: raise error, stay in S_HI.
- S_LO accepts:
  - hex digit: load `byte_out` = {hi, digit}, go to S_OUT;
  - BLANK: discard the stored high nibble, go to S_HI (resync, no error);
  - INVALID: raise error, discard the high nibble, go to S_HI.
- S_OUT:
  - `byte_valid` = 1.
  - `byte_out` is held stable until `byte_ready` is sampled high, then the FSM goes to S_HI.
- Raising an error means:
  - `err_pulse` = 1 for the next cycle;
  - `err_count` increments, saturating at 2^ERR_W−1.
- If `err_clr` and an error occur in the same cycle, `err_clr` wins and `err_count` becomes 0. `err_pulse` still fires.
- When `seg_valid` is low, the FSM holds its state indefinitely. There is no timeout.

## Timing
- Reset values: `seg_ready` = 1, `byte_valid` = 0, `byte_out` = 00, `err_pulse` = 0, `err_count` = 0, FSM in S_HI.
- Reset is synchronous and overrides everything, including mid-byte and S_OUT with `byte_ready` high. A byte that is pending at reset is lost.
- Latency: if the low nibble is accepted at edge N, `byte_valid` is high from edge N until the handshake edge. With `byte_ready` held at 1, the handshake is edge N+1.
- Throughput: at most one byte per 3 cycles (hi, lo, out).
- `err_pulse` goes high on the edge after the offending accept and lasts exactly one cycle.
- All outputs are registered except `seg_ready`, which is decoded from the state register with no input dependence.

## Structure
- Package `seg7_pkg` holds:
  - the 16 pattern constants and `SEG_BLANK`;
  - the state encoding (S_HI, S_LO, S_OUT).
- The DE1 display encoder and the checkers share this package.
- Sub-module `seg7_lookup` is purely combinational. It maps `seg_in` (after polarity normalisation) to {is_hex, is_blank, nibble[3:0]}.
- The top level contains the FSM, nibble/byte registers and the error counter.

## Test plan
- Reset, then present 12 then 21 (digits 5, d) with `byte_ready` = 1 → `byte_out` = 5D, `byte_valid` for exactly one cycle, no error.
- Present 40, 79, then hold `byte_ready` = 0 for 5 cycles → `byte_out` = 01 stable, `seg_ready` = 0 throughout, byte taken when `byte_ready` rises.
- Present 06, then 7F, then 0E, 46 → the E is discarded, output FC, `err_count` = 0.
- Present 55 in S_HI, then 08, 55 → two `err_pulse`s, `err_count` = 2, no byte emitted.
- Send 300 invalid patterns with ERR_W = 8 → `err_count` saturates at FF. Then assert `err_clr` together with another invalid pattern → count = 00, pulse seen.
- Accept the high nibble 00 (8), assert `resetn` = 0 for one cycle, then present 79, 24 → output 12 (the stale 8 is not used). ACTIVE_LOW = 0 run with inverted codes gives identical bytes.
